reg_bus_mst: RTL and testbench
==============================

# reg_bus_mst

Register-bus initiator that drives the CPU side of the register bank. It accepts single read or write commands from the host-interface deserializer (SPI/UART frame decoder) over a valid/ready handshake. For each command it generates the one-hot-in-time `wen`/`ren` strobes with address and data, and captures the OR-merged read data from all registers. It returns one response per command, carrying read data and an error flag.

## Interface
- `DW`, 8, register data width; matches the register bank.
- `AW`, 8, register address width.
- `RD_LAT`, 0, extra cycles `o_ren` is held before read data is sampled; legal range 0..3.
- `i_clk` input 1: sole clock, rising edge.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_cmd_vld` input 1: command valid.
- `o_cmd_rdy` output 1: command ready.
- `i_cmd_wr` input 1: 1 means write (a write-1-to-clear on clearable registers), 0 means read.
- `i_cmd_addr` input AW: target register address.
- `i_cmd_wdata` input DW: write data; ignored for reads.
- `i_test_mode_status` input 1: chip is in test mode.
- `i_cfg_mode_status` input 1: chip is in cfg mode.
- `o_wen` output 1: bus write strobe.
- `o_ren` output 1: bus read strobe.
- `o_addr` output AW: bus address.
- `o_wdata` output DW: bus write data.
- `i_rdata` input DW: OR of all register `o_rdata`; combinational from `o_ren`/`o_addr`.
- `o_rsp_vld` output 1: response valid.
- `i_rsp_rdy` input 1: response ready.
- `o_rsp_rdata` output DW: read data; 0 for writes and errors.
- `o_rsp_err` output 1: command rejected; no bus access was made.
- `o_busy` output 1: high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: `o_cmd_rdy`=1.
  - WR: `o_wen`=1 for exactly one cycle.
  - RD: `o_ren`=1 for RD_LAT+1 cycles, tracked by a down-counter.
  - RSP: `o_rsp_vld`=1.
- IDLE transitions on `i_cmd_vld & o_cmd_rdy`:
  - If neither mode status is set in the accept cycle, go to RSP with `o_rsp_err`=1 and `o_rsp_rdata`=0.
  - Otherwise go to WR if `i_cmd_wr`=1, else to RD.
- On accept, `i_cmd_addr` and `i_cmd_wdata` are registered into `o_addr` and `o_wdata`. Both hold that value until the next accept; they are never cleared in IDLE.
- WR always goes to RSP after one cycle, with `o_rsp_rdata`=0 and `o_rsp_err`=0.
- RD captures `i_rdata` into `o_rsp_rdata` on the clock edge that ends its last `o_ren` cycle, then goes to RSP.
- RSP holds `o_rsp_vld`, `o_rsp_rdata` and `o_rsp_err` stable until `i_rsp_rdy`=1, then returns to IDLE.
- A mode-status change after accept does not abort a bus access in progress. Per-register gating in the bank decides whether the access takes effect.
- `o_wen` and `o_ren` are never high in the same cycle. Each is only ever high in WR or RD respectively.
- Exactly one response is produced per accepted command. Commands never overlap.

## Timing
- Reset values: state IDLE; `o_cmd_rdy`=1 (the only output that resets high); all other outputs 0, including `o_addr` and `o_wdata`.
- Reset in mid-operation: on the next edge every output takes its reset value and any in-flight command is dropped with no response.
- Write, accepted at edge of cycle N:
  - cycle N+1: `o_wen`=1.
  - cycle N+2: `o_rsp_vld`=1.
- Read, accepted at edge of cycle N:
  - cycles N+1 .. N+1+RD_LAT: `o_ren`=1.
  - cycle N+2+RD_LAT: `o_rsp_vld`=1.
- Error, accepted at edge of cycle N: `o_rsp_vld`=1 in cycle N+1.
- When the response handshake completes at cycle M, `o_cmd_rdy`=1 in cycle M+1. Peak throughput is therefore one write per 3 cycles.
- Outputs are registered, with one exception: `o_cmd_rdy` may be decoded combinationally from the state register.

## Test plan
- Write, cfg mode=1, addr=0x12, wdata=0xA5:
  - `o_wen` is high for exactly one cycle with `o_addr`=0x12 and `o_wdata`=0xA5.
  - `o_rsp_vld` is high the next cycle, with err=0 and rdata=0.
- Read with RD_LAT=0, then RD_LAT=2, addr=0x34; bench returns `i_rdata`=0x5C only while `o_ren` and `o_addr`=0x34:
  - `o_ren` is high for 1 or 3 cycles respectively.
  - Response rdata=0x5C at cycle N+2+RD_LAT.
- Both mode statuses 0, read addr=0x01:
  - No `o_wen` or `o_ren` pulse.
  - Response at N+1 with err=1 and rdata=0.
- Response backpressure, `i_rsp_rdy` held 0 for 5 cycles after a read of 0xC3:
  - rsp fields remain stable and `o_cmd_rdy`=0 throughout.
  - A second `i_cmd_vld` is not accepted until one cycle after `i_rsp_rdy`=1.
- Back-to-back write then read with `i_rsp_rdy` tied 1:
  - Each command produces exactly one response, in order.
  - `o_wen` and `o_ren` are never high together.
- Assert `i_rst` during the second RD cycle with RD_LAT=2:
  - Next cycle `o_ren`=0, `o_rsp_vld`=0 and `o_cmd_rdy`=1.
  - No response is ever issued for that command.

Source files
------------

// File: rtl/reg_bus_mst.sv
// reg_bus_mst: register-bus initiator for the CPU side of the register bank.
// Takes single read/write commands over a valid/ready handshake, issues the
// one-cycle write strobe or the (RD_LAT+1)-cycle read strobe, captures the
// OR-merged read data, and returns exactly one response per command.
// Commands never overlap: a new command is only taken in IDLE.
module reg_bus_mst #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_vld,
  output logic          o_cmd_rdy,
  input  logic          i_cmd_wr,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_wdata,
  input  logic          i_test_mode_status,
  input  logic          i_cfg_mode_status,
  output logic          o_wen,
  output logic          o_ren,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic          o_rsp_vld,
  input  logic          i_rsp_rdy,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

  // RD_LAT is limited to 0..3, so a 2-bit down-counter covers every hold length.
  localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] lat_cnt;
  logic       accept;
  logic       mode_ok;

  // Ready is the only output decoded straight from the state register.
  assign o_cmd_rdy = (state == IDLE);
  assign accept    = i_cmd_vld & o_cmd_rdy;
  assign mode_ok   = i_test_mode_status | i_cfg_mode_status;

  // Next-state decode; mode status only matters in the accept cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!mode_ok)      state_nxt = RSP;
          else if (i_cmd_wr) state_nxt = WR;
          else               state_nxt = RD;
        end
      end
      WR:      state_nxt = RSP;
      RD:      if (lat_cnt == 2'd0) state_nxt = RSP;
      RSP:     if (i_rsp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus strobes/flags registered from the next state, so each
  // strobe is high exactly while the FSM sits in its matching state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_wen     <= 1'b0;
      o_ren     <= 1'b0;
      o_rsp_vld <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_wen     <= (state_nxt == WR);
      o_ren     <= (state_nxt == RD);
      o_rsp_vld <= (state_nxt == RSP);
      o_busy    <= (state_nxt != IDLE);
    end
  end

  // Command capture, read-hold counting and response payload; address and
  // write data persist until the next accepted command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_addr      <= '0;
      o_wdata     <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      lat_cnt     <= 2'd0;
    end else if (accept) begin
      o_addr      <= i_cmd_addr;
      o_wdata     <= i_cmd_wdata;
      o_rsp_rdata <= '0;
      o_rsp_err   <= ~mode_ok;
      lat_cnt     <= RD_LAT_C;
    end else if (state == RD) begin
      if (lat_cnt == 2'd0) o_rsp_rdata <= i_rdata;
      else                 lat_cnt     <= lat_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_reg_bus_mst.sv
// tb_reg_bus_mst: two initiators (RD_LAT 0 and 2) against a small register
// bank model; expected responses are queued at command time and compared
// when each response handshake happens.
module tb_reg_bus_mst;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_vld[2], cmd_wr[2], test_ms[2], cfg_ms[2], rsp_rdy[2];
  logic [7:0] cmd_addr[2], cmd_wdata[2], rdata[2];
  logic       cmd_rdy[2], wen[2], ren[2], rsp_vld[2], rsp_err[2], busy[2];
  logic [7:0] addr[2], wdata[2], rsp_rdata[2];

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Register bank model: OR-merged read data, only non-zero while reading.
  function automatic logic [7:0] bank(input logic [7:0] a);
    case (a)
      8'h34:   return 8'h5C;
      8'h56:   return 8'hC3;
      default: return {a[3:0], a[7:4]} ^ 8'h3C;
    endcase
  endfunction

  assign rdata[0] = ren[0] ? bank(addr[0]) : 8'h00;
  assign rdata[1] = ren[1] ? bank(addr[1]) : 8'h00;

  reg_bus_mst #(.DW(8), .AW(8), .RD_LAT(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_vld(cmd_vld[0]), .o_cmd_rdy(cmd_rdy[0]), .i_cmd_wr(cmd_wr[0]),
    .i_cmd_addr(cmd_addr[0]), .i_cmd_wdata(cmd_wdata[0]),
    .i_test_mode_status(test_ms[0]), .i_cfg_mode_status(cfg_ms[0]),
    .o_wen(wen[0]), .o_ren(ren[0]), .o_addr(addr[0]), .o_wdata(wdata[0]),
    .i_rdata(rdata[0]), .o_rsp_vld(rsp_vld[0]), .i_rsp_rdy(rsp_rdy[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]), .o_busy(busy[0])
  );

  reg_bus_mst #(.DW(8), .AW(8), .RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_vld(cmd_vld[1]), .o_cmd_rdy(cmd_rdy[1]), .i_cmd_wr(cmd_wr[1]),
    .i_cmd_addr(cmd_addr[1]), .i_cmd_wdata(cmd_wdata[1]),
    .i_test_mode_status(test_ms[1]), .i_cfg_mode_status(cfg_ms[1]),
    .o_wen(wen[1]), .o_ren(ren[1]), .o_addr(addr[1]), .o_wdata(wdata[1]),
    .i_rdata(rdata[1]), .o_rsp_vld(rsp_vld[1]), .i_rsp_rdy(rsp_rdy[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]), .o_busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input int d);
    rsp_t g;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      g = sb.pop_front();
      chk("rsp_err", rsp_err[d], g.err);
      chk("rsp_rdata", rsp_rdata[d], g.rdata);
    end
  endtask

  // One command on DUT d; modes = {test, cfg}; bp = cycles of held-off ready.
  task automatic do_cmd(input int d, input logic wr, input logic [1:0] modes,
                        input logic [7:0] a, input logic [7:0] wd, input int bp);
    rsp_t e;
    int   k, nwen, nren, exp_lat, exp_ren, exp_wen;
    logic both;
    e.err   = (modes == 2'b00);
    e.rdata = (e.err || wr) ? 8'h00 : bank(a);
    exp_lat = e.err ? 1 : (wr ? 2 : 2 + 2 * d);
    exp_ren = (e.err || wr) ? 0 : 1 + 2 * d;
    exp_wen = (!e.err && wr) ? 1 : 0;
    @(negedge clk);
    chk("cmd_rdy_idle", cmd_rdy[d], 1);
    cmd_vld[d] = 1'b1; cmd_wr[d] = wr; cmd_addr[d] = a; cmd_wdata[d] = wd;
    test_ms[d] = modes[1]; cfg_ms[d] = modes[0]; rsp_rdy[d] = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    // Drop modes and scramble fields: the access must run from captured values.
    cmd_vld[d] = 1'b0; test_ms[d] = 1'b0; cfg_ms[d] = 1'b0;
    cmd_addr[d] = 8'hFF; cmd_wdata[d] = 8'h00;
    k = 0; nwen = 0; nren = 0; both = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (wen[d]) begin
        nwen++;
        chk("wen_addr", addr[d], a);
        chk("wen_wdata", wdata[d], wd);
      end
      if (ren[d]) begin
        nren++;
        chk("ren_addr", addr[d], a);
      end
      if (wen[d] && ren[d]) both = 1'b1;
    end while (!rsp_vld[d] && k < 20);
    chk("rsp_timeout", rsp_vld[d], 1);
    chk("rsp_latency", k, exp_lat);
    chk("wen_cycles", nwen, exp_wen);
    chk("ren_cycles", nren, exp_ren);
    chk("wen_ren_overlap", both, 0);
    for (int i = 0; i < bp; i++) begin
      // A competing command must not be taken while the response is stalled.
      cmd_vld[d] = 1'b1; cmd_wr[d] = 1'b1; cfg_ms[d] = 1'b1; cmd_addr[d] = 8'h77;
      @(negedge clk);
      chk("bp_vld", rsp_vld[d], 1);
      chk("bp_rdata", rsp_rdata[d], e.rdata);
      chk("bp_err", rsp_err[d], e.err);
      chk("bp_cmd_rdy", cmd_rdy[d], 0);
      chk("bp_wen", wen[d], 0);
    end
    rsp_rdy[d] = 1'b1;
    pop_cmp(d);
    @(posedge clk); #1;
    cmd_vld[d] = 1'b0; cfg_ms[d] = 1'b0;
    @(negedge clk);
    chk("post_rsp_vld", rsp_vld[d], 0);
    chk("post_cmd_rdy", cmd_rdy[d], 1);
    chk("post_busy", busy[d], 0);
    rsp_rdy[d] = 1'b0;
  endtask

  // Write, read, write on DUT0 with response ready tied high.
  task automatic back_to_back();
    int   got, cyc, overlap;
    rsp_t e;
    rsp_rdy[0] = 1'b1; cfg_ms[0] = 1'b1;
    got = 0; cyc = 0; overlap = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int w;
          @(negedge clk);
          cmd_vld[0]   = 1'b1;
          cmd_wr[0]    = (i != 1);
          cmd_addr[0]  = (i == 1) ? 8'h34 : 8'h20 + 8'(i);
          cmd_wdata[0] = 8'h11 + 8'(i);
          w = 0;
          while (!cmd_rdy[0] && w < 10) begin
            @(negedge clk);
            w++;
          end
          if (w >= 10) chk("b2b_accept_timeout", 1, 0);
          e.err   = 1'b0;
          e.rdata = (i == 1) ? 8'h5C : 8'h00;
          sb.push_back(e);
          @(posedge clk); #1;
          cmd_vld[0] = 1'b0;
        end
      end
      begin
        while (got < 3 && cyc < 40) begin
          @(negedge clk);
          cyc++;
          if (wen[0] && ren[0]) overlap++;
          if (rsp_vld[0]) begin
            pop_cmp(0);
            got++;
          end
        end
      end
    join
    chk("b2b_rsp_count", got, 3);
    chk("b2b_overlap", overlap, 0);
    chk("b2b_sb_empty", sb.size(), 0);
    rsp_rdy[0] = 1'b0; cfg_ms[0] = 1'b0;
  endtask

  // Reset during the second read-strobe cycle of DUT2 drops the command.
  task automatic reset_mid_read();
    int nrsp;
    @(negedge clk);
    cmd_vld[1] = 1'b1; cmd_wr[1] = 1'b0; cmd_addr[1] = 8'h34; cfg_ms[1] = 1'b1;
    rsp_rdy[1] = 1'b1;
    @(posedge clk); #1;
    cmd_vld[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_ren", ren[1], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ren", ren[1], 0);
    chk("rst_rsp_vld", rsp_vld[1], 0);
    chk("rst_cmd_rdy", cmd_rdy[1], 1);
    chk("rst_addr", addr[1], 0);
    chk("rst_busy", busy[1], 0);
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_vld[1]) nrsp++;
    end
    chk("rst_no_rsp", nrsp, 0);
    cfg_ms[1] = 1'b0; rsp_rdy[1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cmd_vld[d] = 1'b0; cmd_wr[d] = 1'b0; test_ms[d] = 1'b0; cfg_ms[d] = 1'b0;
      rsp_rdy[d] = 1'b0; cmd_addr[d] = 8'h00; cmd_wdata[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_cmd_rdy", cmd_rdy[d], 1);
      chk("rst_strobes", {wen[d], ren[d]}, 0);
      chk("rst_rsp", {rsp_vld[d], rsp_err[d], rsp_rdata[d]}, 0);
      chk("rst_bus", {addr[d], wdata[d]}, 0);
      chk("rst_busy", busy[d], 0);
    end
    do_cmd(0, 1'b1, 2'b01, 8'h12, 8'hA5, 0);
    do_cmd(0, 1'b0, 2'b01, 8'h34, 8'h00, 0);
    do_cmd(1, 1'b0, 2'b01, 8'h34, 8'h00, 0);
    do_cmd(0, 1'b0, 2'b00, 8'h01, 8'h00, 0);
    do_cmd(1, 1'b0, 2'b10, 8'h56, 8'h00, 5);
    do_cmd(1, 1'b1, 2'b00, 8'h22, 8'h99, 0);
    back_to_back();
    reset_mid_read();
    do_cmd(1, 1'b1, 2'b10, 8'h40, 8'h3C, 0);
    do_cmd(1, 1'b0, 2'b11, 8'h40, 8'h00, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
